z1010_dsp_macc_slice: RTL and testbench

- Cycle-accurate behavioural model of the z1010 hard DSP slice: signed 18x18 multiply, optional 40-bit post-add of C or accumulator feedback, and optional input, multiplier and output registers.
- It is the execution end of the DSP techmap flow. Every efpga_mult*/efpga_macc* configuration the mapper emits corresponds to one parameter set of this block.
- Used as the simulation and equivalence target for mapped netlists.

---
 rtl/z1010_dsp_macc_slice.sv | 172 +++++++++++++++++
 tb/tb_z1010_dsp_macc_slice.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z1010_dsp_macc_slice.sv
// z1010 hard DSP slice: signed 18x18 multiply, optional 40-bit post-add of C or
// accumulator feedback, with optional input, product and output registers.
module z1010_dsp_macc_slice #(
  parameter int REG_IN   = 0,
  parameter int MULT_REG = 0,
  parameter int REG_OUT  = 0,
  parameter int ADD_C    = 0,
  parameter int FEEDBACK = 0
) (
  input  logic               CLK,
  input  logic               ARST,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic               ACC_CLR,
  input  logic signed [17:0] A,
  input  logic signed [17:0] B,
  input  logic signed [39:0] C,
  output logic signed [39:0] P,
  output logic               OUT_VALID
);
  localparam int DATA_W = 18;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 40;

  function automatic logic signed [PROD_W-1:0] mult(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] b_x;
    a_x = {{DATA_W{a[DATA_W-1]}}, a};
    b_x = {{DATA_W{b[DATA_W-1]}}, b};
    return a_x * b_x;
  endfunction

  // Sums wrap modulo 2^40; there is deliberately no saturation.
  function automatic logic signed [ACC_W-1:0] post_add(input logic signed [PROD_W-1:0] prod,
                                                        input logic signed [ACC_W-1:0]  addend);
    return {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} + addend;
  endfunction

  if (FEEDBACK != 0 && (ADD_C == 0 || REG_OUT == 0)) begin : g_bad_cfg
    $error("z1010_dsp_macc_slice: FEEDBACK=1 needs ADD_C=1 and REG_OUT=1");
  end

  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic signed [ACC_W-1:0]  c_p0;
  logic                     vld_p0, clr_p0;
  logic                     clr_in;

  assign clr_in = IN_VALID & ACC_CLR;

  // ---- stage p0: input register ----
  if (REG_IN != 0) begin : g_reg_in
    logic signed [DATA_W-1:0] a_p0_q, b_p0_q;
    logic signed [ACC_W-1:0]  c_p0_q;
    logic                     vld_p0_q, clr_p0_q;
    always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
        a_p0_q   <= '0;
        b_p0_q   <= '0;
        c_p0_q   <= '0;
        vld_p0_q <= 1'b0;
        clr_p0_q <= 1'b0;
      end else if (CE) begin
        a_p0_q   <= A;
        b_p0_q   <= B;
        c_p0_q   <= C;
        vld_p0_q <= IN_VALID;
        clr_p0_q <= clr_in;
      end
    end
    assign a_p0   = a_p0_q;
    assign b_p0   = b_p0_q;
    assign c_p0   = c_p0_q;
    assign vld_p0 = vld_p0_q;
    assign clr_p0 = clr_p0_q;
  end else begin : g_comb_in
    assign a_p0   = A;
    assign b_p0   = B;
    assign c_p0   = C;
    assign vld_p0 = IN_VALID;
    assign clr_p0 = clr_in;
  end

  logic signed [PROD_W-1:0] prod_p1_d, prod_p1;
  logic signed [ACC_W-1:0]  c_p1;
  logic                     vld_p1, clr_p1;

  assign prod_p1_d = mult(a_p0, b_p0);

  // ---- stage p1: product register ----
  if (MULT_REG != 0) begin : g_mult_reg
    logic signed [PROD_W-1:0] prod_p1_q;
    logic signed [ACC_W-1:0]  c_p1_q;
    logic                     vld_p1_q, clr_p1_q;
    always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
        prod_p1_q <= '0;
        c_p1_q    <= '0;
        vld_p1_q  <= 1'b0;
        clr_p1_q  <= 1'b0;
      end else if (CE) begin
        prod_p1_q <= prod_p1_d;
        c_p1_q    <= c_p0;
        vld_p1_q  <= vld_p0;
        clr_p1_q  <= clr_p0;
      end
    end
    assign prod_p1 = prod_p1_q;
    assign c_p1    = c_p1_q;
    assign vld_p1  = vld_p1_q;
    assign clr_p1  = clr_p1_q;
  end else begin : g_comb_mult
    assign prod_p1 = prod_p1_d;
    assign c_p1    = c_p0;
    assign vld_p1  = vld_p0;
    assign clr_p1  = clr_p0;
  end

  logic signed [ACC_W-1:0] p_p2;
  logic                    vld_p2;

  // ---- stage p2: post-adder and output / accumulator register ----
  if (FEEDBACK != 0) begin : g_acc
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    vld_p2_q;
    // Bubbles leave the running sum untouched.
    always_comb begin
      acc_d = acc_q;
      if (vld_p1) acc_d = post_add(prod_p1, clr_p1 ? '0 : acc_q);
    end
    always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
        acc_q    <= '0;
        vld_p2_q <= 1'b0;
      end else if (CE) begin
        acc_q    <= acc_d;
        vld_p2_q <= vld_p1;
      end
    end
    assign p_p2   = acc_q;
    assign vld_p2 = vld_p2_q;
  end else begin : g_no_acc
    logic signed [ACC_W-1:0] sum_p2_d;
    assign sum_p2_d = post_add(prod_p1, (ADD_C != 0) ? c_p1 : '0);
    if (REG_OUT != 0) begin : g_reg_out
      logic signed [ACC_W-1:0] p_p2_q;
      logic                    vld_p2_q;
      always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
          p_p2_q   <= '0;
          vld_p2_q <= 1'b0;
        end else if (CE) begin
          p_p2_q   <= sum_p2_d;
          vld_p2_q <= vld_p1;
        end
      end
      assign p_p2   = p_p2_q;
      assign vld_p2 = vld_p2_q;
    end else begin : g_comb_out
      assign p_p2   = sum_p2_d;
      assign vld_p2 = vld_p1;
    end
  end

  logic unused_tags;
  assign unused_tags = ^{clr_p1, c_p1};

  // Reset also masks the combinational path, so P/OUT_VALID read 0 in every configuration.
  assign P         = ARST ? '0 : p_p2;
  assign OUT_VALID = ~ARST & vld_p2;

endmodule

// File: tb/tb_z1010_dsp_macc_slice.sv
// Bench for z1010_dsp_macc_slice: four parameterisations share one stimulus bus;
// directed tables/sequences plus a randomized run against a behavioural model.
module tb_z1010_dsp_macc_slice;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               ARST, CE, IN_VALID, ACC_CLR;
  logic signed [17:0] A, B;
  logic signed [39:0] C;
  logic signed [39:0] p_a, p_b, p_c, p_d;
  logic               v_a, v_b, v_c, v_d;

  // L=0 with C post-add
  z1010_dsp_macc_slice #(.REG_IN(0), .MULT_REG(0), .REG_OUT(0), .ADD_C(1), .FEEDBACK(0)) u_comb (
    .CLK(CLK), .ARST(ARST), .CE(CE), .IN_VALID(IN_VALID), .ACC_CLR(ACC_CLR),
    .A(A), .B(B), .C(C), .P(p_a), .OUT_VALID(v_a));
  // L=3 plain multiply
  z1010_dsp_macc_slice #(.REG_IN(1), .MULT_REG(1), .REG_OUT(1), .ADD_C(0), .FEEDBACK(0)) u_pipe3 (
    .CLK(CLK), .ARST(ARST), .CE(CE), .IN_VALID(IN_VALID), .ACC_CLR(ACC_CLR),
    .A(A), .B(B), .C(C), .P(p_b), .OUT_VALID(v_b));
  // L=2 accumulator
  z1010_dsp_macc_slice #(.REG_IN(0), .MULT_REG(1), .REG_OUT(1), .ADD_C(1), .FEEDBACK(1)) u_acc (
    .CLK(CLK), .ARST(ARST), .CE(CE), .IN_VALID(IN_VALID), .ACC_CLR(ACC_CLR),
    .A(A), .B(B), .C(C), .P(p_c), .OUT_VALID(v_c));
  // L=2 multiply-add of C
  z1010_dsp_macc_slice #(.REG_IN(1), .MULT_REG(0), .REG_OUT(1), .ADD_C(1), .FEEDBACK(0)) u_pipe2c (
    .CLK(CLK), .ARST(ARST), .CE(CE), .IN_VALID(IN_VALID), .ACC_CLR(ACC_CLR),
    .A(A), .B(B), .C(C), .P(p_d), .OUT_VALID(v_d));

  typedef struct {
    longint a, b, c;
    bit     v, ce;
    longint exp_p;
    bit     exp_v;
  } vec_t;

  typedef struct {
    longint a, b, c;
    bit     v, clr;
  } samp_t;

  int     checks = 0;
  int     errors = 0;
  samp_t  hist[$];
  longint acc_m;
  bit     accv_m;
  samp_t  seq[$];
  longint expq[$];
  longint got[$];
  vec_t   tbl[7];

  function automatic longint wrap40(input longint x);
    logic signed [39:0] t;
    t = x[39:0];
    return t;
  endfunction

  function automatic vec_t mkvec(input longint a, b, c, input bit v, ce, input longint ep, input bit ev);
    vec_t r;
    r.a = a; r.b = b; r.c = c; r.v = v; r.ce = ce; r.exp_p = ep; r.exp_v = ev;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    samp_t z;
    z.a = 0; z.b = 0; z.c = 0; z.v = 1'b0; z.clr = 1'b0;
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(z);
    acc_m  = 0;
    accv_m = 1'b0;
  endtask

  // Each enabled edge shifts one sample in; a stage of latency L sees the sample L-1 back.
  task automatic model_step();
    samp_t s, at_add;
    if (ARST) begin
      model_reset();
    end else if (CE) begin
      s.a = A; s.b = B; s.c = C; s.v = IN_VALID; s.clr = IN_VALID & ACC_CLR;
      hist.push_front(s);
      if (hist.size() > 4) void'(hist.pop_back());
      at_add = hist[1];
      if (at_add.v) acc_m = wrap40(at_add.a * at_add.b + (at_add.clr ? 64'sd0 : acc_m));
      accv_m = at_add.v;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic drive(input longint a, b, c, input bit v, clr, ce);
    A = a[17:0]; B = b[17:0]; C = c[39:0];
    IN_VALID = v; ACC_CLR = clr; CE = ce;
  endtask

  task automatic sq(input longint a, b, input bit v, clr);
    samp_t s;
    s.a = a; s.b = b; s.c = 0; s.v = v; s.clr = clr;
    seq.push_back(s);
  endtask

  task automatic compare_queue(input string tag);
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -64'sd1, expq[i]);
  endtask

  task automatic check_model();
    chk("rnd_pipe3_p",  p_b, wrap40(hist[2].a * hist[2].b));
    chk("rnd_pipe3_v",  v_b, hist[2].v);
    chk("rnd_acc_p",    p_c, acc_m);
    chk("rnd_acc_v",    v_c, accv_m);
    chk("rnd_pipe2c_p", p_d, wrap40(hist[1].a * hist[1].b + hist[1].c));
    chk("rnd_pipe2c_v", v_d, hist[1].v);
  endtask

  initial begin
    logic [63:0] r;
    longint ia[9], ib[9], ep[9];
    bit     iv[9], ev[9];

    tbl[0] = mkvec(-3, 7, 100, 1, 1, 79, 1);
    tbl[1] = mkvec(-131072, -131072, 0, 1, 1, 64'sd17179869184, 1);
    tbl[2] = mkvec(131071, 131071, 64'sd549755813887, 1, 1, -64'sd532576206848, 1);
    tbl[3] = mkvec(5, -6, -10, 0, 1, -40, 0);
    tbl[4] = mkvec(-131072, 131071, 0, 1, 0, -64'sd17179738112, 1);
    tbl[5] = mkvec(0, 123, -1, 1, 1, -1, 1);
    tbl[6] = mkvec(1000, -1000, -64'sd549755813888, 1, 1, 64'sd549754813888, 1);

    ia = '{1, 2, 0, 3, 4, 5, 0, 0, 0};
    ib = '{2, 3, 0, 4, 5, 6, 0, 0, 0};
    iv = '{1, 1, 0, 1, 1, 1, 0, 0, 0};
    ep = '{0, 0, 2, 6, 0, 12, 20, 30, 0};
    ev = '{0, 0, 1, 1, 0, 1, 1, 1, 0};

    // Reset with live inputs: reset must win everywhere, including the combinational slice.
    ARST = 1'b1;
    drive(-3, 7, 100, 1, 1, 1);
    model_reset();
    repeat (2) tick();
    chk("rst_comb_p", p_a, 0);  chk("rst_comb_v", v_a, 0);
    chk("rst_pipe3_p", p_b, 0); chk("rst_pipe3_v", v_b, 0);
    chk("rst_acc_p", p_c, 0);   chk("rst_acc_v", v_c, 0);
    chk("rst_p2c_p", p_d, 0);   chk("rst_p2c_v", v_d, 0);
    @(negedge CLK);
    ARST = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) tick();

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v, 1'b0, tbl[i].ce);
      #1;
      chk($sformatf("comb_p_%0d", i), p_a, tbl[i].exp_p);
      chk($sformatf("comb_v_%0d", i), v_a, tbl[i].exp_v);
    end
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) tick();

    // Three-register stream with a bubble after the second sample.
    for (int j = 0; j < 9; j++) begin
      drive(ia[j], ib[j], 0, iv[j], 0, 1);
      tick();
      chk($sformatf("stream_p_%0d", j), p_b, ep[j]);
      chk($sformatf("stream_v_%0d", j), v_b, ev[j]);
    end
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) tick();

    // Accumulator: restarts, bubbles, ignored clear, and the wrap at 2^39.
    sq(2, 3, 1, 1); sq(4, 5, 1, 0); sq(-1, 10, 1, 0); sq(1, 1, 1, 1);
    sq(3, 3, 1, 1); sq(2, 2, 1, 1);
    sq(5, 5, 1, 1); sq(9, 9, 0, 1); sq(1, 2, 1, 0);
    sq(-131072, -131072, 1, 1);
    for (int k = 0; k < 30; k++) sq(-131072, -131072, 1, 0);
    sq(131071, 131071, 1, 0); sq(2, 131071, 1, 0); sq(1, 1, 1, 0);
    expq = '{6, 26, 16, 1, 9, 4, 25, 27};
    for (int k = 1; k <= 31; k++) expq.push_back(longint'(k) << 34);
    expq.push_back((longint'(31) << 34) + 64'sd17179607041);
    expq.push_back(64'sd549755813887);
    expq.push_back(-64'sd549755813888);
    got.delete();
    foreach (seq[i]) begin
      drive(seq[i].a, seq[i].b, 0, seq[i].v, seq[i].clr, 1);
      tick();
      if (v_c) got.push_back(p_c);
    end
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) begin
      tick();
      if (v_c) got.push_back(p_c);
    end
    compare_queue("acc");
    chk("acc_wrap_final", p_c, -64'sd549755813888);
    repeat (2) tick();

    // Stall: CE low four cycles with the pipe full.
    got.delete();
    expq.delete();
    for (int k = 1; k <= 8; k++) expq.push_back(2 * k);
    for (int k = 1; k <= 4; k++) begin
      drive(k, 2, 0, 1, 0, 1);
      tick();
      if (v_b) got.push_back(p_b);
    end
    drive(5, 2, 0, 1, 0, 0);
    repeat (4) begin
      tick();
      chk("stall_p", p_b, 4);
      chk("stall_v", v_b, 1);
    end
    for (int k = 5; k <= 8; k++) begin
      drive(k, 2, 0, 1, 0, 1);
      tick();
      if (v_b) got.push_back(p_b);
    end
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) begin
      tick();
      if (v_b) got.push_back(p_b);
    end
    compare_queue("stall");

    // Reset between edges with samples in flight.
    for (int k = 1; k <= 3; k++) begin
      drive(k, 3, 0, 1, 0, 1);
      tick();
    end
    @(negedge CLK);
    ARST = 1'b1;
    #1;
    chk("mid_rst_comb_p", p_a, 0);  chk("mid_rst_comb_v", v_a, 0);
    chk("mid_rst_pipe3_p", p_b, 0); chk("mid_rst_pipe3_v", v_b, 0);
    chk("mid_rst_acc_p", p_c, 0);   chk("mid_rst_acc_v", v_c, 0);
    chk("mid_rst_p2c_p", p_d, 0);   chk("mid_rst_p2c_v", v_d, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    ARST = 1'b0;
    repeat (2) begin
      tick();
      chk("post_rst_idle_v", v_b, 0);
      chk("post_rst_idle_p", p_b, 0);
    end
    drive(7, 3, 0, 1, 0, 1);
    tick();
    chk("post_rst_e0_v", v_b, 0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("post_rst_e1_v", v_b, 0);
    tick();
    chk("post_rst_e2_v", v_b, 1);
    chk("post_rst_e2_p", p_b, 21);

    // Randomized run against the model.
    @(negedge CLK);
    ARST = 1'b1;
    tick();
    @(negedge CLK);
    ARST = 1'b0;
    model_reset();
    for (int it = 0; it < 400; it++) begin
      r = {$urandom(), $urandom()};
      A = 18'($urandom());
      B = 18'($urandom());
      if ($urandom_range(0, 7) == 0) A = -18'sd131072;
      if ($urandom_range(0, 7) == 0) B = -18'sd131072;
      C        = r[39:0];
      IN_VALID = ($urandom_range(0, 3) != 0);
      ACC_CLR  = ($urandom_range(0, 4) == 0);
      CE       = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_comb_p", p_a, wrap40(longint'(A) * longint'(B) + longint'(C)));
      chk("rnd_comb_v", v_a, IN_VALID);
      tick();
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
